// File: rtl/test_scoreboard.sv
// Scoreboard that queues expected words, checks each returned actual against the queue head
// and keeps pass/fail statistics, with an end-of-test drain, idle timeout and flush.
module test_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exp_valid,
  input  logic [DATA_W-1:0]       exp_data,
  output logic                    exp_ready,
  input  logic                    act_valid,
  input  logic [DATA_W-1:0]       act_data,
  output logic                    act_ready,
  input  logic                    end_of_test,
  output logic [63:0]             stats,
  output logic                    mismatch,
  output logic [DATA_W-1:0]       mismatch_exp,
  output logic [DATA_W-1:0]       mismatch_act,
  output logic                    timed_out,
  output logic                    done,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, rdPtr_q;
  logic [AW:0]       fill_q, fill_d;
  logic [IW-1:0]     idle_q, idle_d, idleInc;
  logic [31:0]       passCnt_q, passCnt_d, failCnt_q, failCnt_d;
  logic              mismatch_q, timedOut_q, timedOut_d, done_q;
  logic [DATA_W-1:0] misExp_q, misAct_q, headData;
  logic              push, pop, flushPop, anyPop, isMatch;

  assign exp_ready = (state_q == RUN) && (fill_q < DEPTH_C);
  assign act_ready = ((state_q == RUN) || (state_q == DRAIN)) && (fill_q != '0);
  assign push      = exp_valid && exp_ready;
  assign pop       = act_valid && act_ready;
  assign flushPop  = (state_q == FLUSH) && (fill_q != '0);
  assign anyPop    = pop || flushPop;
  assign headData  = mem_q[rdPtr_q];
  assign isMatch   = (act_data == headData);
  assign idleInc   = idle_q + 1'b1;

  assign stats        = {passCnt_q, failCnt_q};
  assign mismatch     = mismatch_q;
  assign mismatch_exp = misExp_q;
  assign mismatch_act = misAct_q;
  assign timed_out    = timedOut_q;
  assign done         = done_q;
  assign fill         = fill_q;

  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    timedOut_d = timedOut_q;
    fill_d     = fill_q;
    passCnt_d  = passCnt_q;
    failCnt_d  = failCnt_q;

    if (push && !anyPop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push && anyPop) begin
      fill_d = fill_q - 1'b1;
    end

    if (pop && isMatch && (passCnt_q != '1)) begin
      passCnt_d = passCnt_q + 32'd1;
    end
    if (((pop && !isMatch) || flushPop) && (failCnt_q != '1)) begin
      failCnt_d = failCnt_q + 32'd1;
    end

    // Emptying the queue in DRAIN wins over a timeout expiring in the same cycle.
    case (state_q)
      RUN: begin
        if (end_of_test) begin
          state_d = DRAIN;
          idle_d  = '0;
        end
      end
      DRAIN: begin
        if (fill_d == '0) begin
          state_d = DONE;
        end else if (pop) begin
          idle_d = '0;
        end else begin
          idle_d = idleInc;
          if (idleInc == TIMEOUT_C) begin
            state_d    = FLUSH;
            timedOut_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (fill_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      fill_q     <= '0;
      idle_q     <= '0;
      passCnt_q  <= '0;
      failCnt_q  <= '0;
      mismatch_q <= 1'b0;
      misExp_q   <= '0;
      misAct_q   <= '0;
      timedOut_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      idle_q     <= idle_d;
      passCnt_q  <= passCnt_d;
      failCnt_q  <= failCnt_d;
      timedOut_q <= timedOut_d;
      done_q     <= (state_d == DONE);
      mismatch_q <= pop && !isMatch;
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (anyPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      if (pop && !isMatch) begin
        misExp_q <= headData;
        misAct_q <= act_data;
      end
    end
  end

endmodule

// File: tb/tb_test_scoreboard.sv
// Self-checking bench for test_scoreboard: directed scenarios plus a random stream,
// checked against a queue-based model of the scoreboard rules.
module tb_test_scoreboard;

  localparam int DW      = 16;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  localparam int P_RUN   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_FLUSH = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          exp_valid, act_valid, end_of_test;
  logic [DW-1:0] exp_data, act_data;
  logic          exp_ready, act_ready, mismatch, timed_out, done;
  logic [63:0]   stats;
  logic [DW-1:0] mismatch_exp, mismatch_act;
  logic [4:0]    fill;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mq[$];
  logic [31:0]   mPass, mFail;
  int            mPhase, mIdle;
  logic          mTimedOut, mMis;
  logic [DW-1:0] mMisExp, mMisAct;

  logic          pd, pp;
  logic [DW-1:0] hd;
  int            peak, pushIdx, popIdx;
  logic [31:0]   passBefore;

  test_scoreboard #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .end_of_test(end_of_test), .stats(stats),
    .mismatch(mismatch), .mismatch_exp(mismatch_exp), .mismatch_act(mismatch_act),
    .timed_out(timed_out), .done(done), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs();
    checkOutput("stats", stats, {mPass, mFail});
    checkOutput("fill", 64'(fill), 64'(mq.size()));
    checkOutput("mismatch", 64'(mismatch), 64'(mMis));
    checkOutput("mismatch_exp", 64'(mismatch_exp), 64'(mMisExp));
    checkOutput("mismatch_act", 64'(mismatch_act), 64'(mMisAct));
    checkOutput("timed_out", 64'(timed_out), 64'(mTimedOut));
    checkOutput("done", 64'(done), 64'(mPhase == P_DONE));
  endtask

  task automatic doReset();
    rst = 1'b1;
    exp_valid = 1'b0; act_valid = 1'b0; end_of_test = 1'b0;
    exp_data = '0; act_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    mPass = '0; mFail = '0; mPhase = P_RUN; mIdle = 0;
    mTimedOut = 1'b0; mMis = 1'b0; mMisExp = '0; mMisAct = '0;
    checkRegs();
    checkOutput("rst_exp_ready", 64'(exp_ready), 64'd1);
    checkOutput("rst_act_ready", 64'(act_ready), 64'd0);
  endtask

  // One clock cycle: drive inputs, check readies, advance the model, then check registered outputs.
  task automatic applyStimulus(input logic ev, input logic [DW-1:0] ed, input logic av,
                               input logic [DW-1:0] ad, input logic eot,
                               output logic pushed, output logic popped);
    logic expRdy, actRdy;
    logic [DW-1:0] h;
    exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad; end_of_test = eot;
    expRdy = (mPhase == P_RUN) && (mq.size() < DEPTH);
    actRdy = ((mPhase == P_RUN) || (mPhase == P_DRAIN)) && (mq.size() > 0);
    checkOutput("exp_ready", 64'(exp_ready), 64'(expRdy));
    checkOutput("act_ready", 64'(act_ready), 64'(actRdy));
    pushed = ev && expRdy;
    popped = av && actRdy;
    mMis = 1'b0;
    if (popped) begin
      h = mq.pop_front();
      if (h == ad) begin
        if (mPass != 32'hFFFF_FFFF) mPass++;
      end else begin
        if (mFail != 32'hFFFF_FFFF) mFail++;
        mMis = 1'b1; mMisExp = h; mMisAct = ad;
      end
    end else if (mPhase == P_FLUSH && mq.size() > 0) begin
      void'(mq.pop_front());
      if (mFail != 32'hFFFF_FFFF) mFail++;
    end
    if (pushed) mq.push_back(ed);
    case (mPhase)
      P_RUN:   if (eot) begin mPhase = P_DRAIN; mIdle = 0; end
      P_DRAIN: begin
        if (mq.size() == 0) mPhase = P_DONE;
        else if (popped) mIdle = 0;
        else begin
          mIdle++;
          if (mIdle == TIMEOUT) begin mPhase = P_FLUSH; mTimedOut = 1'b1; end
        end
      end
      P_FLUSH: if (mq.size() == 0) mPhase = P_DONE;
      default: ;
    endcase
    @(posedge clk); #1;
    exp_valid = 1'b0; act_valid = 1'b0; end_of_test = 1'b0;
    checkRegs();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting");

    // Five matching words, then end of test.
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, DW'(i), 1'b0, '0, 1'b0, pd, pp);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, '0, 1'b1, DW'(i), 1'b0, pd, pp);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, pd, pp);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, pd, pp);
    checkOutput("t1_stats", stats, {32'd5, 32'd0});
    checkOutput("t1_done", 64'(done), 64'd1);

    // One pass, one mismatch.
    doReset();
    applyStimulus(1'b1, 16'hA5, 1'b0, '0, 1'b0, pd, pp);
    applyStimulus(1'b1, 16'h5A, 1'b0, '0, 1'b0, pd, pp);
    applyStimulus(1'b0, '0, 1'b1, 16'hA5, 1'b0, pd, pp);
    applyStimulus(1'b0, '0, 1'b1, 16'h00, 1'b0, pd, pp);
    checkOutput("t2_pulse", 64'(mismatch), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, pd, pp);
    checkOutput("t2_pulse_end", 64'(mismatch), 64'd0);
    checkOutput("t2_mis_exp", 64'(mismatch_exp), 64'h5A);
    checkOutput("t2_mis_act", 64'(mismatch_act), 64'h00);
    checkOutput("t2_stats", stats, {32'd1, 32'd1});

    // Overfill by one word: stall until an actual frees a slot.
    doReset();
    pushIdx = 1; popIdx = 1; peak = 0;
    for (int c = 0; c < 60 && popIdx <= 17; c++) begin
      if (c == 16) checkOutput("t3_full_stall", 64'(exp_ready), 64'd0);
      applyStimulus(pushIdx <= 17, DW'(pushIdx), c >= 17, DW'(popIdx), 1'b0, pd, pp);
      if (pd) pushIdx++;
      if (pp) popIdx++;
      if (int'(fill) > peak) peak = int'(fill);
    end
    checkOutput("t3_popped", 64'(popIdx), 64'd18);
    checkOutput("t3_peak", 64'(peak), 64'd16);
    checkOutput("t3_stats", stats, {32'd17, 32'd0});

    // Idle drain times out and flushes the remaining words.
    doReset();
    applyStimulus(1'b1, 16'd10, 1'b0, '0, 1'b0, pd, pp);
    applyStimulus(1'b1, 16'd20, 1'b0, '0, 1'b0, pd, pp);
    applyStimulus(1'b1, 16'd30, 1'b0, '0, 1'b0, pd, pp);
    applyStimulus(1'b0, '0, 1'b1, 16'd10, 1'b1, pd, pp);
    for (int c = 0; c < 40 && done !== 1'b1; c++)
      applyStimulus(1'b0, '0, 1'b0, '0, c == 2, pd, pp);
    checkOutput("t4_timed_out", 64'(timed_out), 64'd1);
    checkOutput("t4_stats", stats, {32'd1, 32'd2});
    checkOutput("t4_done", 64'(done), 64'd1);

    // Simultaneous push and pop across pointer wrap.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, '0, 1'b0, pd, pp);
    passBefore = mPass;
    for (int c = 0; c < 40; c++) begin
      hd = mq[0];
      applyStimulus(1'b1, DW'($urandom), 1'b1, hd, 1'b0, pd, pp);
    end
    checkOutput("t5_fill", 64'(fill), 64'd3);
    checkOutput("t5_passes", 64'(stats[63:32]), 64'(passBefore + 32'd40));

    // Random traffic with occasional wrong actuals, then a clean drain.
    doReset();
    for (int c = 0; c < 150; c++) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) hd = mq[0];
      else hd = DW'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), hd,
                    c == 149, pd, pp);
    end
    for (int c = 0; c < 40 && done !== 1'b1; c++) begin
      hd = (mq.size() > 0) ? mq[0] : '0;
      applyStimulus(1'b0, '0, 1'b1, hd, 1'b0, pd, pp);
    end
    checkOutput("t6_done", 64'(done), 64'd1);

    // Reset in the middle of a flush.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, DW'(i + 100), 1'b0, '0, 1'b0, pd, pp);
    applyStimulus(1'b0, '0, 1'b1, 16'd100, 1'b1, pd, pp);
    for (int c = 0; c < 20 && !(timed_out === 1'b1 && fill == 5'd4); c++)
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, pd, pp);
    checkOutput("t7_pre_fill", 64'(fill), 64'd4);
    doReset();
    checkOutput("t7_fill", 64'(fill), 64'd0);
    checkOutput("t7_stats", stats, 64'd0);
    checkOutput("t7_done", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/test_scoreboard.md
TEST_SCOREBOARD -- requirements
Module: test_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of expected and actual data words.
REQ-002 SHALL have parameter DEPTH, default 16 (power of two, >=2): expected-value FIFO entries.
REQ-003 SHALL have parameter TIMEOUT, default 1024: idle cycles allowed in DRAIN before flushing.
REQ-004 SHALL have port clk  input  1: sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have ports exp_valid input 1, exp_data input DATA_W, exp_ready output 1: expected-value stream.
REQ-007 SHALL have ports act_valid input 1, act_data input DATA_W, act_ready output 1: DUT actual-value stream.
REQ-008 SHALL have port end_of_test  input  1: single-cycle pulse, no further expected values follow.
REQ-009 SHALL have port stats  output  64: {pass_cnt[31:0], fail_cnt[31:0]}, pass_cnt in bits 63:32, matching packed test_stats layout.
REQ-010 SHALL have ports mismatch output 1, mismatch_exp output DATA_W, mismatch_act output DATA_W: one-cycle mismatch report.
REQ-011 SHALL have ports timed_out output 1, done output 1, fill output $clog2(DEPTH)+1: status.

Function
REQ-012 SHALL implement states RUN, DRAIN, FLUSH, DONE; RUN after reset.
REQ-013 SHALL accept an expected word when exp_valid && exp_ready; exp_ready = (state==RUN) && fill<DEPTH; no bypass when full.
REQ-014 SHALL set act_ready = (state==RUN || state==DRAIN) && fill>0; actuals never consumed with FIFO empty.
REQ-015 SHALL, on act handshake, compare act_data with FIFO head and pop head in same cycle.
REQ-016 SHALL update pass_cnt or fail_cnt exactly one cycle after the act handshake (latency 1).
REQ-017 SHALL on mismatch assert mismatch for exactly one cycle, concurrently with the fail_cnt update, with mismatch_exp/act holding the compared words; both hold value until next mismatch.
REQ-018 SHALL, on simultaneous push and pop, keep fill unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-019 SHALL saturate pass_cnt and fail_cnt at 32'hFFFF_FFFF.
REQ-020 SHALL transition RUN->DRAIN on end_of_test; an exp handshake in the same cycle is still accepted.
REQ-021 SHALL in DRAIN go to DONE when fill==0 (evaluated after any pop that cycle).
REQ-022 SHALL in DRAIN count consecutive cycles without act handshake, resetting on handshake; at TIMEOUT cycles go to FLUSH and set timed_out.
REQ-023 SHALL in FLUSH pop one entry per cycle, incrementing fail_cnt per entry without asserting mismatch; go to DONE when fill reaches 0.
REQ-024 SHALL in DONE hold done=1, exp_ready=0, act_ready=0, freeze all counters; leave only via rst.
REQ-025 SHALL ignore end_of_test outside RUN.

Reset
REQ-026 SHALL on rst: state=RUN, fill=0, pointers=0, stats=0, mismatch=0, mismatch_exp/act=0, timed_out=0, done=0, idle counter=0.
REQ-027 SHALL give rst priority over all events; rst mid-DRAIN/FLUSH discards FIFO contents and restarts in RUN next cycle.
REQ-028 SHALL drive exp_ready=1 and act_ready=0 in the first cycle after rst deasserts.

Verification
REQ-029 SHALL cover: push 5 values 1..5, return 1..5, end_of_test -> stats=={32'd5,32'd0}, done=1, mismatch never set.
REQ-030 SHALL cover: push 16'hA5 then 16'h5A, return 16'hA5 then 16'h00 -> pass=1, fail=1, mismatch pulse once with exp=16'h5A, act=16'h00.
REQ-031 SHALL cover: push DEPTH+1 words back-to-back -> exp_ready low on 17th until one act pop; fill peaks 16; all 17 pass in order.
REQ-032 SHALL cover: push 3, return 1, end_of_test, no more actuals, TIMEOUT=8 -> timed_out after 8 idle cycles, fail=2, pass=1, done.
REQ-033 SHALL cover: simultaneous push/pop every cycle for 40 cycles across pointer wrap -> fill constant, 40 passes.
REQ-034 SHALL cover: rst asserted during FLUSH with fill=4 -> next cycle fill=0, stats=0, done=0, state RUN.
